// File: rtl/row_window_buffer.sv
// row_window_buffer
//   Consumer end of the row-streaming image interface. Each rising edge of
//   valid_i captures one W-pixel row into a three-row shift register. Once
//   three rows are held, the block walks a 3x3 window across them (valid
//   convolution, no padding) and hands each window downstream over a
//   valid/ready handshake. When the row has been consumed, done_o pulses
//   for one cycle so the source can send the next row. After H rows the
//   frame bookkeeping is cleared and frame_done_o pulses with that done_o.
//
//   Handshake: a window transfers on every rising clk edge where
//   win_valid_o and win_ready_i are both high. While win_valid_o is high
//   and win_ready_i is low, win_o, col_o and win_valid_o hold stable.
//
// Ports
//   clk, rstn      clock, synchronous active-low reset
//   data_i         row data, pixel k = data_i[8k+7:8k]
//   valid_i        row valid from source (captured on its rising edge)
//   done_o         one-cycle pulse: current row fully consumed
//   win_o          3x3 window, win_o[8*(3r+c)+:8] = row r (0 oldest), column col+c
//   win_valid_o    win_o valid
//   win_ready_i    downstream accepts window
//   col_o          column index of current window
//   row_o          output row index (0..H-3) of current window
//   frame_done_o   one-cycle pulse with the done_o of the last row of a frame
//   overflow_o     sticky: a valid_i rise arrived while busy (row dropped)
module row_window_buffer #(
  parameter int W = 24,
  parameter int H = 24
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [W*8-1:0]           data_i,
  input  logic                     valid_i,
  output logic                     done_o,
  output logic [71:0]              win_o,
  output logic                     win_valid_o,
  input  logic                     win_ready_i,
  // Widths are the number of bits needed to hold W and H respectively.
  output logic [$clog2(W+1)-1:0]   col_o,
  output logic [$clog2(H+1)-1:0]   row_o,
  output logic                     frame_done_o,
  output logic                     overflow_o
);

  localparam int CW = $clog2(W+1);
  localparam int RW = $clog2(H+1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CW-1:0] COL_LAST   = CW'(W - 3);
  localparam logic [RW-1:0] ROWS_FRAME = RW'(H);

  logic [1:0]     state_q, state_d;
  logic [W*8-1:0] r0_q, r0_d;   // oldest row
  logic [W*8-1:0] r1_q, r1_d;
  logic [W*8-1:0] r2_q, r2_d;   // newest row
  logic [1:0]     rows_held_q, rows_held_d;
  logic [RW-1:0]  frame_cnt_q, frame_cnt_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic           valid_d_q;
  logic           overflow_q, overflow_d;

  logic rise;
  logic frame_end;
  logic handshake;

  assign rise      = valid_i & ~valid_d_q;
  assign frame_end = (frame_cnt_q == ROWS_FRAME);
  assign handshake = win_valid_o & win_ready_i;

  always_comb begin
    state_d     = state_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    rows_held_d = rows_held_q;
    frame_cnt_d = frame_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    // A rise outside IDLE drops that row; only the sticky flag records it.
    overflow_d  = overflow_q | (rise & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (rise) begin
          r0_d        = r1_q;
          r1_d        = r2_q;
          r2_d        = data_i;
          rows_held_d = (rows_held_q == 2'd3) ? 2'd3 : rows_held_q + 2'd1;
          frame_cnt_d = frame_cnt_q + RW'(1);
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (rows_held_q == 2'd3) begin
          col_d   = '0;
          state_d = EMIT;
        end else begin
          state_d = DONE;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (col_q == COL_LAST) state_d = DONE;
          else                   col_d   = col_q + CW'(1);
        end
      end
      DONE: begin
        // rows_held is unchanged since capture, so == 3 means windows went out.
        if (rows_held_q == 2'd3) row_d = row_q + RW'(1);
        if (frame_end) begin
          // Row registers keep stale pixels; rows_held = 0 stops them being used.
          rows_held_d = '0;
          frame_cnt_d = '0;
          row_d       = '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      r0_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      rows_held_q <= '0;
      frame_cnt_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      valid_d_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      rows_held_q <= rows_held_d;
      frame_cnt_q <= frame_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      valid_d_q   <= valid_i;
      overflow_q  <= overflow_d;
    end
  end

  // Window is driven only in EMIT so it reads as zero whenever it is not valid.
  always_comb begin
    int base;
    win_o = '0;
    base  = int'(col_q);
    if (state_q == EMIT) begin
      for (int c = 0; c < 3; c++) begin
        win_o[8*c     +: 8] = r0_q[8*(base+c) +: 8];
        win_o[8*(3+c) +: 8] = r1_q[8*(base+c) +: 8];
        win_o[8*(6+c) +: 8] = r2_q[8*(base+c) +: 8];
      end
    end
  end

  assign win_valid_o  = (state_q == EMIT);
  assign done_o       = (state_q == DONE);
  assign frame_done_o = (state_q == DONE) & frame_end;
  assign col_o        = col_q;
  assign row_o        = row_q;
  assign overflow_o   = overflow_q;

endmodule

// File: doc/row_window_buffer.md
Name: row_window_buffer

Overview:
- Consumer end of the row-streaming image interface: accepts one W-pixel row per `valid_i` rising edge and keeps the last three rows in registers.
- Emits 3x3 pixel windows (valid convolution, no padding) to the conv datapath over a valid/ready handshake.
- Returns a one-cycle `done_o` pulse to the row source when the row has been consumed; the source uses it as its `conv_done` input.
- Counts rows per frame and flushes after H rows.

Parameters:
- W, 24, pixels per row (8-bit pixels); W >= 3.
- H, 24, rows per frame; H >= 3.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, synchronous, active-low.
- data_i  input  W*8  row data; pixel k = data_i[8k+7:8k].
- valid_i  input  1  row valid from source; row is captured on its rising edge.
- done_o  output  1  one-cycle pulse: current row fully consumed.
- win_o  output  72  3x3 window; win_o[8*(3r+c)+:8] = row r (0 = oldest), column col+c.
- win_valid_o  output  1  win_o valid.
- win_ready_i  input  1  downstream accepts window.
- col_o  output  clogb2(W)  column index of current window.
- row_o  output  clogb2(H)  output row index (0..H-3) of current window.
- frame_done_o  output  1  one-cycle pulse after last row of frame consumed.
- overflow_o  output  1  sticky: rising edge of valid_i seen while not IDLE.

Behaviour:
- Reset values:
  - done_o, win_valid_o, frame_done_o, overflow_o = 0.
  - col_o, row_o = 0; win_o = 0.
  - Row registers r0/r1/r2 = 0; rows_held = 0; frame row count = 0; valid_d = 0.
  - State = IDLE.
- Edge detect: valid_d <= valid_i every cycle. rise = valid_i & ~valid_d.
- IDLE:
  - On rise, capture: r0<=r1, r1<=r2, r2<=data_i.
  - rows_held saturates at 3; frame row count increments.
  - Go to LOAD.
- LOAD (1 cycle):
  - If rows_held == 3: col <= 0, go to EMIT.
  - Otherwise go to DONE.
- EMIT:
  - win_valid_o = 1; win_o built combinationally from r0/r1/r2 at columns col..col+2; col_o = col.
  - On win_valid_o & win_ready_i:
    - If col == W-3, go to DONE.
    - Else col <= col+1.
  - With win_ready_i low, win_o, col_o and win_valid_o hold stable.
- DONE (1 cycle):
  - done_o = 1; win_valid_o = 0.
  - If a window was emitted this row, row_o <= row_o+1.
  - If frame row count == H:
    - frame_done_o = 1 in the same cycle.
    - Clear rows_held, frame row count and row_o.
    - r0/r1/r2 hold their values but are stale.
  - Go to IDLE.
- Latency, with the rise seen at cycle t (when valid_i goes high):
  - LOAD at t+1.
  - First window valid at t+2.
  - With win_ready_i held high, done_o at t+2+(W-2) = t+W.
  - For rows 1 and 2 of a frame (no windows), done_o at t+2.
- Windows per frame: (H-2)*(W-2); row_o spans 0..H-3.
- Rise while state != IDLE: row dropped, overflow_o <= 1 (sticky until reset), state unaffected.
- A level-high valid_i without a new rise is never re-captured. The source may hold valid_i high until done_o.
- Simultaneous rise in the DONE cycle: counts as an overflow. The source must wait for done_o before raising valid_i again.
- Reset mid-frame or mid-EMIT: all state returns to reset values in the next cycle; any partial row is discarded.
- Widths: clogb2 uses the same definition as the row source (bits to hold the value). All counters compare exactly and never wrap past W-3 or H.

Test Plan:
- W=24, H=24, win_ready_i=1; three rows with pixel k of row n = n*24+k -> no windows for rows 0 and 1, each done_o 2 cycles after its rise. Row 2 -> 22 windows, cols 0..21, first window = {0,1,2,24,25,26,48,49,50} in r-major order, done_o at t+24.
- Same rows; win_ready_i toggled 1,0,1,0 during EMIT -> each window held stable while ready=0, exactly 22 handshakes, no duplicates or skips.
- Full frame of 24 rows -> 484 windows total, row_o 0..21, frame_done_o exactly once, coincident with the 24th done_o. The next frame's third row emits with row_o=0.
- Second valid_i rise during EMIT -> overflow_o=1 and stays high, window sequence unaffected, only one done_o for the row.
- valid_i held high across done_o with no new rise -> no second capture, state stays IDLE.
- rstn low for 1 cycle at column 10 of row 5 -> next cycle all outputs 0 and state IDLE. Following rows behave as a fresh frame (first two rows emit no windows).
